// File: rtl/vm2002_common_pkg.sv
// Shared vm2002 types: coin/status encodings, coin values and change-dispenser FSM states.
package vm2002_common_pkg;

  typedef enum logic [1:0] {
    NO_COINS = 2'd0,
    NICKEL   = 2'd1,
    DIME     = 2'd2,
    QUARTER  = 2'd3
  } coins_t;

  typedef enum logic [1:0] {
    NO_STATUS = 2'd0,
    AVAILABE  = 2'd1,
    ERROR     = 2'd2
  } status_t;

  localparam int COIN_VAL_NICKEL  = 5;
  localparam int COIN_VAL_DIME    = 10;
  localparam int COIN_VAL_QUARTER = 25;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SELECT, S_EJECT, S_DONE, S_FAIL
  } chg_state_t;

endpackage

// File: rtl/vm2002_change_dispenser_if.sv
// Change-request and coin-ejector handshake bundle of the vm2002 change dispenser.
interface vm2002_change_dispenser_if #(parameter int AMT_W = 8);
  import vm2002_common_pkg::*;

  logic             chg_valid;
  logic             chg_ready;
  logic [AMT_W-1:0] chg_amt;
  logic             restock;
  logic             coin_req;
  coins_t           coin_type;
  logic             coin_ack;
  logic             chg_done;
  status_t          chg_status;
  logic [AMT_W-1:0] chg_remaining;

  modport slave (
    input  chg_valid, chg_amt, restock, coin_ack,
    output chg_ready, coin_req, coin_type, chg_done, chg_status, chg_remaining
  );

  modport master (
    output chg_valid, chg_amt, restock, coin_ack,
    input  chg_ready, coin_req, coin_type, chg_done, chg_status, chg_remaining
  );
endinterface

// File: rtl/vm2002_change_dispenser_coin_select.sv
// Greedy coin picker: largest in-stock coin not exceeding the amount still owed.
module vm2002_coin_select
  import vm2002_common_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic             has_quarter,
  input  logic             has_dime,
  input  logic             has_nickel,
  output coins_t           coin,
  output logic [AMT_W-1:0] coin_val
);
  localparam logic [AMT_W-1:0] V_Q = AMT_W'(COIN_VAL_QUARTER);
  localparam logic [AMT_W-1:0] V_D = AMT_W'(COIN_VAL_DIME);
  localparam logic [AMT_W-1:0] V_N = AMT_W'(COIN_VAL_NICKEL);

  always_comb begin
    coin     = NO_COINS;
    coin_val = '0;
    if (remaining >= V_Q && has_quarter) begin
      coin = QUARTER; coin_val = V_Q;
    end else if (remaining >= V_D && has_dime) begin
      coin = DIME;    coin_val = V_D;
    end else if (remaining >= V_N && has_nickel) begin
      coin = NICKEL;  coin_val = V_N;
    end
  end
endmodule

// File: rtl/vm2002_change_dispenser.sv
// Pays out change one coin at a time (quarter/dime/nickel greedy) with per-coin ack timeout.
// VM2002_CHG_INV_EN builds per-denomination inventories and restock; otherwise stock is unlimited.
module vm2002_change_dispenser
  import vm2002_common_pkg::*;
#(
  parameter int AMT_W       = 8,
  parameter int INV_W       = 6,
  parameter int INV_INIT    = 20,
  parameter int ACK_TIMEOUT = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  vm2002_change_dispenser_if.slave bus
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [INV_W-1:0] INV_FULL = INV_W'(INV_INIT);

  chg_state_t       state, nstate;
  logic [AMT_W-1:0] rem, cur_val, sel_val, rem_out;
  coins_t           cur_coin, sel_coin;
  logic [TW-1:0]    tmo_cnt;
  logic             has_q, has_d, has_n, done_r;
  status_t          status_r;

`ifdef VM2002_CHG_INV_EN
  logic [INV_W-1:0] inv_q, inv_d, inv_n;

  // Restock is only honoured in IDLE, so it can never race a decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= INV_FULL; inv_d <= INV_FULL; inv_n <= INV_FULL;
    end else if (state == S_IDLE && bus.restock) begin
      inv_q <= INV_FULL; inv_d <= INV_FULL; inv_n <= INV_FULL;
    end else if (state == S_EJECT && bus.coin_ack) begin
      case (cur_coin)
        QUARTER: inv_q <= inv_q - INV_W'(1);
        DIME:    inv_d <= inv_d - INV_W'(1);
        NICKEL:  inv_n <= inv_n - INV_W'(1);
        default: ;
      endcase
    end
  end

  assign has_q = (inv_q != '0);
  assign has_d = (inv_d != '0);
  assign has_n = (inv_n != '0);
`else
  logic             unused_restock;
  logic [INV_W-1:0] unused_inv;
  assign unused_restock = bus.restock;
  assign unused_inv     = INV_FULL;
  assign has_q = 1'b1;
  assign has_d = 1'b1;
  assign has_n = 1'b1;
`endif

  vm2002_coin_select #(.AMT_W(AMT_W)) u_sel (
    .remaining   (rem),
    .has_quarter (has_q),
    .has_dime    (has_d),
    .has_nickel  (has_n),
    .coin        (sel_coin),
    .coin_val    (sel_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:   if (bus.chg_valid) nstate = (bus.chg_amt == '0) ? S_DONE : S_CHECK;
      S_CHECK:  nstate = ((rem % AMT_W'(5)) != '0) ? S_FAIL : S_SELECT;
      S_SELECT: begin
        if (rem == '0)                nstate = S_DONE;
        else if (sel_coin != NO_COINS) nstate = S_EJECT;
        else                           nstate = S_FAIL;
      end
      S_EJECT: begin
        if (bus.coin_ack)                            nstate = S_SELECT;
        else if (tmo_cnt == TW'(ACK_TIMEOUT - 1))    nstate = S_FAIL;
      end
      S_DONE, S_FAIL: nstate = S_IDLE;
      default:        nstate = S_IDLE;
    endcase
  end

  // Request-side outputs decode straight from state so reset drops coin_req at once.
  always_comb begin
    bus.chg_ready = 1'b0;
    bus.coin_req  = 1'b0;
    bus.coin_type = NO_COINS;
    case (state)
      S_IDLE:  bus.chg_ready = 1'b1;
      S_EJECT: begin
        bus.coin_req  = 1'b1;
        bus.coin_type = cur_coin;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      cur_coin <= NO_COINS;
      cur_val  <= '0;
      tmo_cnt  <= '0;
      done_r   <= 1'b0;
      status_r <= NO_STATUS;
      rem_out  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: if (bus.chg_valid) begin
          rem      <= bus.chg_amt;
          status_r <= NO_STATUS;
        end
        S_SELECT: begin
          cur_coin <= sel_coin;
          cur_val  <= sel_val;
          tmo_cnt  <= '0;
        end
        S_EJECT: begin
          if (bus.coin_ack) rem     <= rem - cur_val;
          else              tmo_cnt <= tmo_cnt + TW'(1);
        end
        S_DONE: begin
          done_r   <= 1'b1;
          status_r <= AVAILABE;
          rem_out  <= '0;
        end
        S_FAIL: begin
          done_r   <= 1'b1;
          status_r <= ERROR;
          rem_out  <= rem;
        end
        default: ;
      endcase
    end
  end

  assign bus.chg_done      = done_r;
  assign bus.chg_status    = status_r;
  assign bus.chg_remaining = rem_out;
endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Bench for vm2002_change_dispenser: directed plan steps plus random requests vs. a greedy payout model.
module tb_vm2002_change_dispenser;
  import vm2002_common_pkg::*;

  localparam int AMT_W       = 8;
  localparam int INV_INIT    = 20;
  localparam int ACK_TIMEOUT = 64;
`ifdef VM2002_CHG_INV_EN
  localparam bit UNLIM = 1'b0;
`else
  localparam bit UNLIM = 1'b1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  vm2002_change_dispenser_if #(.AMT_W(AMT_W)) bus();

  vm2002_change_dispenser #(
    .AMT_W(AMT_W), .INV_W(6), .INV_INIT(INV_INIT), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int      n_vec = 0;
  int      n_err = 0;
  int      inv[3];
  int      val[3]   = '{25, 10, 5};
  coins_t  cname[3] = '{QUARTER, DIME, NICKEL};
  coins_t  exp_q[$];
  coins_t  got_q[$];
  status_t exp_st;
  int      exp_rem;
  bit      spurious = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic restock_model();
    for (int i = 0; i < 3; i++) inv[i] = INV_INIT;
  endtask

  // Greedy payout from the rules: largest coin that fits and is in stock.
  task automatic model(input int amt, input bit tmo);
    int r;
    int k;
    r = amt;
    exp_q.delete();
    if (amt % 5 != 0) begin exp_st = ERROR; exp_rem = amt; return; end
    while (r > 0) begin
      k = -1;
      for (int i = 0; i < 3; i++)
        if (k < 0 && val[i] <= r && (UNLIM || inv[i] > 0)) k = i;
      if (k < 0) begin exp_st = ERROR; exp_rem = r; return; end
      exp_q.push_back(cname[k]);
      if (tmo) begin exp_st = ERROR; exp_rem = r; return; end
      r -= val[k];
      inv[k]--;
    end
    exp_st  = AVAILABE;
    exp_rem = 0;
  endtask

  task automatic do_req(input int amt, input int max_delay, input bit withhold, input bit rs);
    int c, req_start, last_ack, dly, req_cycles;
    bit in_req, done, first;
    if (rs) restock_model();
    model(amt, withhold);
    got_q.delete();
    @(negedge clk);
    chk("ready_before_req", bus.chg_ready, 1);
    bus.chg_amt   = AMT_W'(amt);
    bus.chg_valid = 1'b1;
    bus.restock   = rs;
    @(negedge clk);
    bus.chg_valid = 1'b0;
    bus.restock   = 1'b0;
    c = 1; done = 0; in_req = 0; first = 1; last_ack = 0; req_cycles = 0;
    req_start = 0; dly = 0;
    while (!done && c < 2000) begin
      bus.coin_ack = 1'b0;
      if (bus.chg_done) begin
        done = 1;
      end else if (bus.coin_req) begin
        req_cycles++;
        if (!in_req) begin
          in_req    = 1;
          req_start = c;
          dly       = $urandom_range(0, max_delay);
          got_q.push_back(bus.coin_type);
          chk(first ? "lat_first_req" : "lat_ack_to_req", c, first ? 3 : last_ack + 2);
          first = 0;
        end else begin
          chk("coin_type_hold", bus.coin_type, got_q[$]);
        end
        if (!withhold && c - req_start >= dly) begin
          bus.coin_ack = 1'b1;
          in_req       = 0;
          last_ack     = c;
        end
      end else begin
        chk("coin_type_idle", bus.coin_type, NO_COINS);
        if (spurious && $urandom_range(0, 3) == 0) bus.coin_ack = 1'b1;
      end
      if (!done) begin
        @(negedge clk);
        c++;
      end
    end
    bus.coin_ack = 1'b0;
    chk("done_seen", done, 1);
    if (amt == 0) chk("lat_zero_done", c, 2);
    if (withhold) chk("timeout_len", req_cycles, ACK_TIMEOUT);
    chk("status", bus.chg_status, exp_st);
    chk("remaining", bus.chg_remaining, exp_rem);
    chk("coin_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk("coin_seq", got_q[i], exp_q[i]);
    @(negedge clk);
    chk("done_one_cycle", bus.chg_done, 0);
    chk("status_held", bus.chg_status, exp_st);
  endtask

  initial begin
    int c;
    int amt;
    bus.chg_valid = 1'b0;
    bus.chg_amt   = '0;
    bus.restock   = 1'b0;
    bus.coin_ack  = 1'b0;
    restock_model();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.chg_ready, 1);
    chk("rst_coin_req", bus.coin_req, 0);
    chk("rst_coin_type", bus.coin_type, NO_COINS);
    chk("rst_done", bus.chg_done, 0);
    chk("rst_status", bus.chg_status, NO_STATUS);
    chk("rst_remaining", bus.chg_remaining, 0);
    rst_n = 1'b1;

    do_req(65, 0, 0, 0);
    do_req(0, 0, 0, 0);
    do_req(37, 0, 0, 0);

    @(negedge clk); bus.restock = 1'b1;
    @(negedge clk); bus.restock = 1'b0;
    restock_model();
    repeat (10) do_req(50, 1, 0, 0);
    do_req(30, 0, 0, 0);

    do_req(25, 0, 1, 1);

    // Reset in the middle of an ejection.
    @(negedge clk);
    bus.chg_amt = AMT_W'(50); bus.chg_valid = 1'b1;
    @(negedge clk);
    bus.chg_valid = 1'b0;
    c = 0;
    while (!bus.coin_req && c < 10) begin @(negedge clk); c++; end
    chk("rst_mid_req_seen", bus.coin_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req_drop", bus.coin_req, 0);
    chk("rst_mid_type", bus.coin_type, NO_COINS);
    @(negedge clk); rst_n = 1'b1;
    restock_model();
    @(negedge clk);
    chk("rst_mid_ready", bus.chg_ready, 1);
    chk("rst_mid_status", bus.chg_status, NO_STATUS);
    chk("rst_mid_done", bus.chg_done, 0);
    do_req(10, 2, 0, 0);

    spurious = 1'b1;
    repeat (25) begin
      if ($urandom_range(0, 3) == 0) amt = $urandom_range(0, 255);
      else                           amt = 5 * $urandom_range(0, 51);
      do_req(amt, 3, 0, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
